l2_fill_arbiter: RTL and testbench
==================================

# l2_fill_arbiter

Shares the single L2$ request/response port between the I$ line-fill path and the D$ fill/writeback path. It accepts one line transaction at a time from either L1 and forwards it to L2. It captures the L2 response and returns it to the requester that owns the transaction. The block sits between the L1 caches and the L2$, with one transaction in flight at any time.

## Interface
- ADDR_WIDTH, 32, physical address width
- LINE_SIZE, 64, cache line size in bytes; OFFSET = $clog2(LINE_SIZE)

- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- ic_req_valid_i  input  1  I$ fill request
- ic_req_addr_i  input  ADDR_WIDTH  I$ fill physical address
- ic_req_ready_o  output  1  I$ request accepted
- ic_resp_valid_o  output  1  I$ fill data valid
- ic_resp_data_o  output  LINE_SIZE*8  I$ fill line
- ic_resp_ready_i  input  1  I$ takes response
- dc_req_valid_i  input  1  D$ request
- dc_req_we_i  input  1  1 = writeback, 0 = fill
- dc_req_addr_i  input  ADDR_WIDTH  D$ physical address
- dc_req_wdata_i  input  LINE_SIZE*8  writeback line
- dc_req_ready_o  output  1  D$ request accepted
- dc_resp_valid_o  output  1  D$ response valid (fill data or write ack)
- dc_resp_data_o  output  LINE_SIZE*8  D$ fill line; zero on write ack
- dc_resp_ready_i  input  1  D$ takes response
- l2_req_valid_o  output  1  request to L2
- l2_req_ready_i  input  1  L2 accepts request
- l2_req_we_o  output  1  write request
- l2_req_addr_o  output  ADDR_WIDTH  line-aligned address
- l2_req_wdata_o  output  LINE_SIZE*8  write line
- l2_resp_valid_i  input  1  L2 response valid
- l2_resp_data_i  input  LINE_SIZE*8  L2 read line
- l2_resp_ready_o  output  1  arbiter takes L2 response

## Operation
- The FSM has four states: IDLE, REQ, WAIT and RESP.
- **IDLE**
  - Grant is computed combinationally from the valid inputs and the priority pointer `prio` (0 = I$, 1 = D$).
  - Only the granted requester sees req_ready_o = 1.
  - On a valid&&ready handshake, the block latches owner, addr, we and wdata, then goes to REQ.
- **Address alignment**: the latched address has bits [OFFSET-1:0] forced to 0.
- **Grant rule**
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester selected by `prio` is granted.
- **REQ**
  - l2_req_valid_o = 1 with the latched we/addr/wdata held stable.
  - On l2_req_ready_i, go to WAIT.
- **WAIT**
  - l2_resp_ready_o = 1.
  - On l2_resp_valid_i, latch l2_resp_data_i into the response buffer and go to RESP.
  - For a writeback, the response buffer is loaded with zero.
- **RESP**
  - The owner's resp_valid_o = 1 and its resp_data_o is driven from the buffer.
  - The non-owner's resp_valid_o = 0.
  - On the owner's resp_ready_i, return to IDLE and set `prio` to the non-owner (round-robin).
- I$ transactions are always reads. The block ignores dc_req_we_i, dc_req_addr_i and dc_req_wdata_i unless the D$ is granted.
- Requests arriving outside IDLE see req_ready_o = 0. Requesters hold valid and payload until accepted.
- l2_resp_valid_i outside WAIT is a protocol error: it is ignored and l2_resp_ready_o stays 0.

## Timing
- **Reset**
  - Asynchronous reset forces state = IDLE and `prio` = 0.
  - The response buffer and latched request are cleared to 0.
  - All outputs are 0, except ic_req_ready_o, which follows the IDLE grant.
  - Reset mid-transaction abandons the transaction; no response is delivered.
- **Minimum latency**
  - Cycle 0: handshake.
  - Cycle 1: l2_req_valid_o = 1; if l2_req_ready_i = 1, the block enters WAIT at cycle 2.
  - Cycle 2: if l2_resp_valid_i = 1, resp_valid_o = 1 at cycle 3.
  - Cycle 3: with resp_ready_i = 1, the block is back in IDLE at cycle 4.
  - Back-to-back transactions therefore take 4 cycles each.
- **Stalls**: each state holds indefinitely while its exit condition is low. All outputs stay stable while stalled.
- **Output timing**: all L2-side outputs and resp outputs are registered or derived from state only. req_ready_o is combinational from req_valid_i and `prio`.

## Configuration
- L2_ARB_DC_PRIORITY_EN: when defined, D$ always wins when both requests are valid, and `prio` is neither used nor updated.
- Without the macro, the round-robin rule above applies.

## Test plan
- **Single I$ fill**: ic_req addr 0x0000_1234, L2 ready immediately, resp data 0xA5…A5.
  - Required: l2_req_addr_o = 0x0000_1200 and l2_req_we_o = 0.
  - Required: ic_resp_valid_o = 1 at cycle 3 with data A5…A5; dc_resp_valid_o = 0.
- **D$ writeback**: we = 1, wdata = 0x5A…5A, addr 0x8000_0040.
  - Required: l2_req_we_o = 1 and l2_req_wdata_o = 5A…5A.
  - Required: dc_resp_valid_o = 1 with data 0.
- **Simultaneous requests, round-robin**: both valid continuously for 4 transactions.
  - Required: grant order I$, D$, I$, D$.
  - With L2_ARB_DC_PRIORITY_EN: D$ granted all 4 times.
- **Stalls**: l2_req_ready_i low for 5 cycles, l2_resp_valid_i delayed 7 cycles, resp_ready_i low 3 cycles.
  - Required: outputs stable throughout each stall and no duplicate L2 request.
  - Required: total latency 4 + 15 = 19 cycles.
- **Reset in WAIT**: rst_ni pulled low with a transaction pending.
  - Required: all outputs 0 immediately, state IDLE, `prio` = 0.
  - Required: a new I$ request after reset completes normally.
- **Request during busy**: dc_req_valid_i raised while an I$ transaction is in REQ.
  - Required: dc_req_ready_o = 0 until IDLE.
  - Required: D$ is granted on the first IDLE cycle.

Source files
------------

// File: rtl/l2_fill_arbiter.sv
// Single-outstanding arbiter sharing the L2$ port between I$ fills and D$ fills/writebacks.
// Optional macro L2_ARB_DC_PRIORITY_EN: D$ wins every tie and the round-robin pointer is removed.
module l2_fill_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_SIZE  = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ic_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]     ic_req_addr_i,
    output logic                      ic_req_ready_o,
    output logic                      ic_resp_valid_o,
    output logic [LINE_SIZE*8-1:0]    ic_resp_data_o,
    input  logic                      ic_resp_ready_i,
    input  logic                      dc_req_valid_i,
    input  logic                      dc_req_we_i,
    input  logic [ADDR_WIDTH-1:0]     dc_req_addr_i,
    input  logic [LINE_SIZE*8-1:0]    dc_req_wdata_i,
    output logic                      dc_req_ready_o,
    output logic                      dc_resp_valid_o,
    output logic [LINE_SIZE*8-1:0]    dc_resp_data_o,
    input  logic                      dc_resp_ready_i,
    output logic                      l2_req_valid_o,
    input  logic                      l2_req_ready_i,
    output logic                      l2_req_we_o,
    output logic [ADDR_WIDTH-1:0]     l2_req_addr_o,
    output logic [LINE_SIZE*8-1:0]    l2_req_wdata_o,
    input  logic                      l2_resp_valid_i,
    input  logic [LINE_SIZE*8-1:0]    l2_resp_data_i,
    output logic                      l2_resp_ready_o
);
    localparam int unsigned LINE_W = LINE_SIZE * 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e                  r_state;
    logic                    r_owner;       // 0 = I$, 1 = D$
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_W-1:0]       r_wdata;
    logic [LINE_W-1:0]       r_buf;
    logic                    r_l2_req_valid;
    logic                    r_l2_resp_ready;
    logic                    r_ic_resp_valid;
    logic                    r_dc_resp_valid;
`ifndef L2_ARB_DC_PRIORITY_EN
    logic                    r_prio;
`endif

    logic w_idle;
    logic w_gnt_ic;
    logic w_gnt_dc;
    logic w_owner_ready;

    always_comb begin
        w_idle = (r_state == S_IDLE);
`ifdef L2_ARB_DC_PRIORITY_EN
        w_gnt_dc = dc_req_valid_i;
        w_gnt_ic = ic_req_valid_i && !dc_req_valid_i;
`else
        w_gnt_ic = ic_req_valid_i && (!dc_req_valid_i || !r_prio);
        w_gnt_dc = dc_req_valid_i && (!ic_req_valid_i || r_prio);
`endif
        w_owner_ready = r_owner ? dc_resp_ready_i : ic_resp_ready_i;
    end

    assign ic_req_ready_o  = w_idle && w_gnt_ic;
    assign dc_req_ready_o  = w_idle && w_gnt_dc;
    assign l2_req_valid_o  = r_l2_req_valid;
    assign l2_req_we_o     = r_we;
    assign l2_req_addr_o   = r_addr;
    assign l2_req_wdata_o  = r_wdata;
    assign l2_resp_ready_o = r_l2_resp_ready;
    assign ic_resp_valid_o = r_ic_resp_valid;
    assign dc_resp_valid_o = r_dc_resp_valid;
    // The non-owner never sees the buffered line.
    assign ic_resp_data_o  = r_ic_resp_valid ? r_buf : '0;
    assign dc_resp_data_o  = r_dc_resp_valid ? r_buf : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= S_IDLE;
            r_owner         <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_buf           <= '0;
            r_l2_req_valid  <= 1'b0;
            r_l2_resp_ready <= 1'b0;
            r_ic_resp_valid <= 1'b0;
            r_dc_resp_valid <= 1'b0;
`ifndef L2_ARB_DC_PRIORITY_EN
            r_prio          <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_dc) begin
                        r_owner        <= 1'b1;
                        r_we           <= dc_req_we_i;
                        r_addr         <= dc_req_addr_i & ALIGN_MASK;
                        r_wdata        <= dc_req_wdata_i;
                        r_l2_req_valid <= 1'b1;
                        r_state        <= S_REQ;
                    end else if (w_gnt_ic) begin
                        r_owner        <= 1'b0;
                        r_we           <= 1'b0;
                        r_addr         <= ic_req_addr_i & ALIGN_MASK;
                        r_wdata        <= '0;
                        r_l2_req_valid <= 1'b1;
                        r_state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (l2_req_ready_i) begin
                        r_l2_req_valid  <= 1'b0;
                        r_l2_resp_ready <= 1'b1;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (l2_resp_valid_i) begin
                        r_buf           <= r_we ? '0 : l2_resp_data_i;
                        r_l2_resp_ready <= 1'b0;
                        r_ic_resp_valid <= !r_owner;
                        r_dc_resp_valid <= r_owner;
                        r_state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_owner_ready) begin
                        r_ic_resp_valid <= 1'b0;
                        r_dc_resp_valid <= 1'b0;
`ifndef L2_ARB_DC_PRIORITY_EN
                        r_prio          <= !r_owner;
`endif
                        r_state         <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_fill_arbiter.sv
// Directed bench for l2_fill_arbiter: scoreboard of expected grants/responses, immediate-assert checks.
module tb_l2_fill_arbiter;
    localparam int AW = 32;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          ic_req_valid_i, ic_req_ready_o, ic_resp_valid_o, ic_resp_ready_i;
    logic [AW-1:0] ic_req_addr_i;
    logic [LW-1:0] ic_resp_data_o;
    logic          dc_req_valid_i, dc_req_we_i, dc_req_ready_o, dc_resp_valid_o, dc_resp_ready_i;
    logic [AW-1:0] dc_req_addr_i;
    logic [LW-1:0] dc_req_wdata_i, dc_resp_data_o;
    logic          l2_req_valid_o, l2_req_ready_i, l2_req_we_o, l2_resp_valid_i, l2_resp_ready_o;
    logic [AW-1:0] l2_req_addr_o;
    logic [LW-1:0] l2_req_wdata_o, l2_resp_data_i;

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    l2_fill_arbiter #(.ADDR_WIDTH(AW), .LINE_SIZE(64)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o), .ic_resp_ready_i(ic_resp_ready_i),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_we_i(dc_req_we_i), .dc_req_addr_i(dc_req_addr_i),
        .dc_req_wdata_i(dc_req_wdata_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_data_o(dc_resp_data_o), .dc_resp_ready_i(dc_resp_ready_i),
        .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i), .l2_req_we_o(l2_req_we_o),
        .l2_req_addr_o(l2_req_addr_o), .l2_req_wdata_o(l2_req_wdata_o),
        .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_data_i(l2_resp_data_i), .l2_resp_ready_o(l2_resp_ready_o)
    );

    typedef struct {
        bit          owner;
        bit          we;
        logic [31:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push(input bit owner, input bit we, input logic [31:0] addr,
                        input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
        txn_t e;
        e.owner = owner; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic chk_busy_req(input txn_t e);
        chk("l2_req_valid", l2_req_valid_o, 1);
        chk("l2_req_addr", l2_req_addr_o, e.addr);
        chk("l2_req_we", l2_req_we_o, e.we);
        if (e.we) chk("l2_req_wdata", l2_req_wdata_o, e.wdata);
        chk("busy_ic_ready", ic_req_ready_o, 0);
        chk("busy_dc_ready", dc_req_ready_o, 0);
        chk("req_resp_ready", l2_resp_ready_o, 0);
    endtask

    // Runs one transaction from the IDLE grant to the return to IDLE, with optional stalls.
    task automatic run_txn(input int req_stall, input int resp_delay, input int rr_stall,
                           input bit hold, input bit raise_dc, output int lat);
        txn_t e;
        int   t0;
        lat = 0;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e = sb[0];
        #1;
        chk("grant_ic", ic_req_ready_o, !e.owner);
        chk("grant_dc", dc_req_ready_o, e.owner);
        cyc;
        t0 = cycle_cnt;
        if (!hold) begin
            if (e.owner) dc_req_valid_i = 0;
            else         ic_req_valid_i = 0;
        end
        if (raise_dc) begin
            dc_req_valid_i = 1; dc_req_we_i = 0; dc_req_addr_i = 32'h0000_30C4;
            dc_req_wdata_i = rand_line();
            push(1, 0, 32'h0000_30C0, '0, {16{32'hC0DE_0001}});
        end
        for (int i = 0; i < req_stall; i++) begin
            #1;
            chk_busy_req(e);
            l2_resp_valid_i = 1;
            l2_resp_data_i  = rand_line();
            cyc;
        end
        l2_resp_valid_i = 0;
        #1;
        chk_busy_req(e);
        l2_req_ready_i = 1;
        cyc;
        l2_req_ready_i = 0;
        for (int i = 0; i <= resp_delay; i++) begin
            #1;
            chk("no_dup_req", l2_req_valid_o, 0);
            chk("wait_resp_ready", l2_resp_ready_o, 1);
            chk("wait_ic_resp", ic_resp_valid_o, 0);
            chk("wait_dc_resp", dc_resp_valid_o, 0);
            chk("wait_ic_ready", ic_req_ready_o, 0);
            chk("wait_dc_ready", dc_req_ready_o, 0);
            if (i == resp_delay) begin
                l2_resp_valid_i = 1;
                l2_resp_data_i  = e.rdata;
            end
            cyc;
        end
        l2_resp_valid_i = 0;
        l2_resp_data_i  = rand_line();
        for (int i = 0; i <= rr_stall; i++) begin
            #1;
            chk("resp_ic_valid", ic_resp_valid_o, !e.owner);
            chk("resp_dc_valid", dc_resp_valid_o, e.owner);
            if (e.owner) chk("resp_dc_data", dc_resp_data_o, e.we ? '0 : e.rdata);
            else         chk("resp_ic_data", ic_resp_data_o, e.rdata);
            chk("resp_l2_ready", l2_resp_ready_o, 0);
            chk("resp_l2_valid", l2_req_valid_o, 0);
            chk("resp_ic_ready", ic_req_ready_o, 0);
            chk("resp_dc_ready", dc_req_ready_o, 0);
            if (i == rr_stall) begin
                if (e.owner) dc_resp_ready_i = 1;
                else         ic_resp_ready_i = 1;
            end
            cyc;
        end
        ic_resp_ready_i = 0;
        dc_resp_ready_i = 0;
        lat = cycle_cnt - t0 + 1;
        #1;
        chk("idle_ic_resp", ic_resp_valid_o, 0);
        chk("idle_dc_resp", dc_resp_valid_o, 0);
        void'(sb.pop_front());
    endtask

    int lat;

    initial begin
        rst_ni = 0;
        ic_req_valid_i = 0; ic_req_addr_i = '0; ic_resp_ready_i = 0;
        dc_req_valid_i = 0; dc_req_we_i = 0; dc_req_addr_i = '0; dc_req_wdata_i = '0; dc_resp_ready_i = 0;
        l2_req_ready_i = 0; l2_resp_valid_i = 0; l2_resp_data_i = '0;
        cyc; cyc;

        // Reset state
        chk("rst_l2_req_valid", l2_req_valid_o, 0);
        chk("rst_l2_addr", l2_req_addr_o, 0);
        chk("rst_l2_wdata", l2_req_wdata_o, 0);
        chk("rst_l2_resp_ready", l2_resp_ready_o, 0);
        chk("rst_ic_resp", ic_resp_valid_o, 0);
        chk("rst_dc_resp", dc_resp_valid_o, 0);
        chk("rst_ic_ready_idle", ic_req_ready_o, 0);
        ic_req_valid_i = 1;
        #1;
        chk("rst_ic_ready_follows", ic_req_ready_o, 1);
        ic_req_valid_i = 0;
        cyc;
        rst_ni = 1;
        cyc;

        // Single I$ fill at minimum latency
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_1234;
        push(0, 0, 32'h0000_1200, '0, {64{8'hA5}});
        run_txn(0, 0, 0, 0, 0, lat);
        chk("lat_min", lat, 4);

        // Reset while in WAIT abandons the transaction
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_4440;
        #1;
        chk("rstw_grant", ic_req_ready_o, 1);
        cyc;
        ic_req_valid_i = 0;
        l2_req_ready_i = 1;
        cyc;
        l2_req_ready_i = 0;
        #1;
        chk("rstw_in_wait", l2_resp_ready_o, 1);
        #2 rst_ni = 0;
        #1;
        chk("rstw_l2_resp_ready", l2_resp_ready_o, 0);
        chk("rstw_l2_req_valid", l2_req_valid_o, 0);
        chk("rstw_l2_addr", l2_req_addr_o, 0);
        chk("rstw_ic_resp", ic_resp_valid_o, 0);
        chk("rstw_dc_resp", dc_resp_valid_o, 0);
        chk("rstw_ic_ready", ic_req_ready_o, 0);
        cyc;
        rst_ni = 1;
        cyc;

        // Both valid after reset: prio back at I$; then D$ writeback
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_2A7F;
        dc_req_valid_i = 1; dc_req_we_i = 1; dc_req_addr_i = 32'h8000_0040; dc_req_wdata_i = {64{8'h5A}};
`ifdef L2_ARB_DC_PRIORITY_EN
        push(1, 1, 32'h8000_0040, {64{8'h5A}}, {16{32'h1111_2222}});
        push(0, 0, 32'h0000_2A40, '0, {16{32'h3C3C_0F0F}});
`else
        push(0, 0, 32'h0000_2A40, '0, {16{32'h3C3C_0F0F}});
        push(1, 1, 32'h8000_0040, {64{8'h5A}}, {16{32'h1111_2222}});
`endif
        run_txn(0, 0, 0, 0, 0, lat);
        run_txn(0, 0, 0, 0, 0, lat);

        // Both valid continuously for 4 transactions
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0100;
        dc_req_valid_i = 1; dc_req_we_i = 0; dc_req_addr_i = 32'h0000_0200; dc_req_wdata_i = rand_line();
        for (int k = 0; k < 4; k++) begin
`ifdef L2_ARB_DC_PRIORITY_EN
            push(1, 0, 32'h0000_0200, '0, rand_line());
`else
            if (k % 2 == 0) push(0, 0, 32'h0000_0100, '0, rand_line());
            else            push(1, 0, 32'h0000_0200, '0, rand_line());
`endif
        end
        for (int k = 0; k < 4; k++) run_txn(0, 0, 0, 1, 0, lat);
        ic_req_valid_i = 0; dc_req_valid_i = 0;
        cyc;

        // Stalls in every phase
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_5555;
        push(0, 0, 32'h0000_5540, '0, rand_line());
        run_txn(5, 7, 3, 0, 0, lat);
        chk("lat_stall", lat, 19);

        // D$ raised while I$ is in flight; granted on the first IDLE cycle
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_6000;
        push(0, 0, 32'h0000_6000, '0, rand_line());
        run_txn(0, 0, 0, 0, 1, lat);
        run_txn(0, 0, 0, 0, 0, lat);
        chk("lat_busy_dc", lat, 4);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
